flash_read_arbiter: RTL and testbench

//  Owns the board SPI flash pins and runs 0x03 READ bursts for two requesters,
//  e.g. requester 0 = text display pager, requester 1 = font/asset loader.

---
 rtl/flash_pkg.sv | 40 ++++
 rtl/spi_bit_shifter.sv | 73 +++++++
 rtl/flash_read_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_flash_read_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// +-------------------------------------------------------------------------+
// | flash_pkg : shared constants, state encoding and round-robin helper     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package flash_pkg;

  localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
  localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;
  localparam int         ADDR_W              = 24;
  localparam int         BIT_PERIOD          = 2;

  localparam logic [2:0] ST_ENC_WAIT_POWER = 3'd0;
  localparam logic [2:0] ST_ENC_IDLE       = 3'd1;
  localparam logic [2:0] ST_ENC_CMD        = 3'd2;
  localparam logic [2:0] ST_ENC_ADDR       = 3'd3;
  localparam logic [2:0] ST_ENC_DUMMY      = 3'd4;
  localparam logic [2:0] ST_ENC_READ       = 3'd5;
  localparam logic [2:0] ST_ENC_CSHIGH     = 3'd6;

  typedef enum logic [2:0] {
    S_WAIT_POWER = ST_ENC_WAIT_POWER,
    S_IDLE       = ST_ENC_IDLE,
    S_CMD        = ST_ENC_CMD,
    S_ADDR       = ST_ENC_ADDR,
    S_DUMMY      = ST_ENC_DUMMY,
    S_READ       = ST_ENC_READ,
    S_CSHIGH     = ST_ENC_CSHIGH
  } state_t;

  // Contested grants go to the requester that was not served last.
  function automatic logic rr_pick(input logic [1:0] req, input logic rr_last);
    if (&req) return ~rr_last;
    return req[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_bit_shifter.sv
// +-------------------------------------------------------------------------+
// | spi_bit_shifter : mode-0 SPI bit engine, MSB-first TX, byte-wide RX     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module spi_bit_shifter
  import flash_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [5:0]  i_nbits,
  input  logic        i_miso,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_done,
  output logic [7:0]  o_rx_byte
);

  localparam logic [3:0] c_last_phase = 4'(BIT_PERIOD - 1);
  localparam logic [3:0] c_half       = 4'(BIT_PERIOD / 2);

  logic        r_active;
  logic [3:0]  r_phase;
  logic [5:0]  r_bitcnt;
  logic [31:0] r_tx;
  logic [7:0]  r_rx;

  // Done is combinational so the sequencer can reload without a gap bit.
  assign o_done    = r_active && (r_phase == c_last_phase) && (r_bitcnt == 6'd0);
  assign o_rx_byte = {r_rx[6:0], i_miso};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_active <= 1'b0;
      r_phase  <= 4'd0;
      r_bitcnt <= 6'd0;
      r_tx     <= 32'd0;
      r_rx     <= 8'd0;
      o_sck    <= 1'b0;
      o_mosi   <= 1'b0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_phase  <= 4'd0;
      r_bitcnt <= i_nbits - 6'd1;
      r_tx     <= {i_data[30:0], 1'b0};
      o_mosi   <= i_data[31];
      o_sck    <= 1'b0;
    end else if (r_active) begin
      if (r_phase == c_last_phase) begin
        r_rx    <= {r_rx[6:0], i_miso};
        o_sck   <= 1'b0;
        r_phase <= 4'd0;
        if (r_bitcnt == 6'd0) begin
          r_active <= 1'b0;
          o_mosi   <= 1'b0;
        end else begin
          r_bitcnt <= r_bitcnt - 6'd1;
          o_mosi   <= r_tx[31];
          r_tx     <= {r_tx[30:0], 1'b0};
        end
      end else begin
        r_phase <= r_phase + 4'd1;
        o_sck   <= ((r_phase + 4'd1) >= c_half);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/flash_read_arbiter.sv
// +-------------------------------------------------------------------------+
// | flash_read_arbiter : two-requester round-robin SPI flash READ sequencer |
// | Build option FLASH_FAST_READ_EN: 0x0B opcode plus 8 dummy bit periods.  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module flash_read_arbiter
  import flash_pkg::*;
#(
  parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
  parameter logic [7:0]  CS_IDLE      = 8'd2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  reqValid,
  input  logic [23:0] reqAddr0,
  input  logic [23:0] reqAddr1,
  input  logic [7:0]  reqLen0,
  input  logic [7:0]  reqLen1,
  output logic [1:0]  reqAck,
  output logic [7:0]  rdByte,
  output logic        rdValid,
  output logic        rdLast,
  output logic        rdOwner,
  output logic        busy,
  output logic        flashClk,
  output logic        flashMosi,
  output logic        flashCs,
  input  logic        flashMiso
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] c_opcode = FLASH_CMD_FAST_READ;
`else
  localparam logic [7:0] c_opcode = FLASH_CMD_READ;
`endif

  state_t              r_state;
  logic [31:0]         r_wait_cnt;
  logic [7:0]          r_cs_cnt;
  logic [8:0]          r_byte_cnt;
  logic [7:0]          r_len;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rr_last;

  logic                w_grant;
  logic                w_load;
  logic [31:0]         w_load_data;
  logic [5:0]          w_nbits;
  logic                w_done;
  logic [7:0]          w_rx_byte;
  logic                w_final_byte;

  assign w_final_byte = (r_byte_cnt == {1'b0, r_len});

  always_comb begin
    w_grant     = rr_pick(reqValid, r_rr_last);
    w_load      = 1'b0;
    w_load_data = 32'd0;
    w_nbits     = 6'd8;
    case (r_state)
      S_IDLE: begin
        w_load      = |reqValid;
        w_load_data = {c_opcode, 24'h000000};
      end
      S_CMD: begin
        w_load      = w_done;
        w_load_data = {r_addr, 8'h00};
        w_nbits     = 6'd24;
      end
      S_ADDR, S_DUMMY: w_load = w_done;
      S_READ:          w_load = w_done && !w_final_byte;
      default:         w_load = 1'b0;
    endcase
  end

  spi_bit_shifter u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (w_load),
    .i_data    (w_load_data),
    .i_nbits   (w_nbits),
    .i_miso    (flashMiso),
    .o_sck     (flashClk),
    .o_mosi    (flashMosi),
    .o_done    (w_done),
    .o_rx_byte (w_rx_byte)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_WAIT_POWER;
      r_wait_cnt <= 32'd0;
      r_cs_cnt   <= 8'd0;
      r_byte_cnt <= 9'd0;
      r_len      <= 8'd0;
      r_addr     <= '0;
      r_rr_last  <= 1'b1;
      reqAck     <= 2'b00;
      rdByte     <= 8'd0;
      rdValid    <= 1'b0;
      rdLast     <= 1'b0;
      rdOwner    <= 1'b0;
      busy       <= 1'b1;
      flashCs    <= 1'b1;
    end else begin
      reqAck  <= 2'b00;
      rdValid <= 1'b0;
      rdLast  <= 1'b0;
      case (r_state)
        S_WAIT_POWER: begin
          if (r_wait_cnt >= STARTUP_WAIT) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
        S_IDLE: begin
          if (|reqValid) begin
            reqAck     <= w_grant ? 2'b10 : 2'b01;
            flashCs    <= 1'b0;
            rdOwner    <= w_grant;
            r_rr_last  <= w_grant;
            r_addr     <= w_grant ? reqAddr1 : reqAddr0;
            r_len      <= w_grant ? reqLen1 : reqLen0;
            r_byte_cnt <= 9'd0;
            busy       <= 1'b1;
            r_state    <= S_CMD;
          end
        end
        S_CMD: if (w_done) r_state <= S_ADDR;
        S_ADDR: begin
          if (w_done) begin
`ifdef FLASH_FAST_READ_EN
            r_state <= S_DUMMY;
`else
            r_state <= S_READ;
`endif
          end
        end
        S_DUMMY: if (w_done) r_state <= S_READ;
        S_READ: begin
          // The idle IDLE cycle before the next grant also counts toward CS high time.
          if (rdLast) begin
            flashCs  <= 1'b1;
            r_cs_cnt <= 8'd1;
            if (CS_IDLE <= 8'd1) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= S_CSHIGH;
            end
          end else if (w_done) begin
            rdByte     <= w_rx_byte;
            rdValid    <= 1'b1;
            rdLast     <= w_final_byte;
            r_byte_cnt <= r_byte_cnt + 9'd1;
          end
        end
        S_CSHIGH: begin
          if (r_cs_cnt >= (CS_IDLE - 8'd1)) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_cs_cnt <= r_cs_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_WAIT_POWER;
          busy    <= 1'b1;
          flashCs <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flash_read_arbiter.sv
// +-------------------------------------------------------------------------+
// | tb_flash_read_arbiter : randomized bench with SPI flash model and       |
// | timing/round-robin reference; honours FLASH_FAST_READ_EN.  Rev 1.0      |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_flash_read_arbiter;

`ifdef FLASH_FAST_READ_EN
  localparam int         c_hdr_bits = 40;
  localparam int         c_first    = 96;
  localparam logic [7:0] c_opcode   = 8'h0B;
`else
  localparam int         c_hdr_bits = 32;
  localparam int         c_first    = 80;
  localparam logic [7:0] c_opcode   = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  reqValid = 2'b00;
  logic [23:0] reqAddr0 = 24'd0;
  logic [23:0] reqAddr1 = 24'd0;
  logic [7:0]  reqLen0 = 8'd0;
  logic [7:0]  reqLen1 = 8'd0;
  logic [1:0]  reqAck;
  logic [7:0]  rdByte;
  logic        rdValid;
  logic        rdLast;
  logic        rdOwner;
  logic        busy;
  logic        flashClk;
  logic        flashMosi;
  logic        flashCs;
  logic        flashMiso = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_rr;
  logic [1:0]  pend;
  logic [23:0] q_addr [2];
  int          q_len [2];

  flash_read_arbiter #(.STARTUP_WAIT(32'd16), .CS_IDLE(8'd2)) dut (
    .clk(clk), .rstn(rstn), .reqValid(reqValid),
    .reqAddr0(reqAddr0), .reqAddr1(reqAddr1), .reqLen0(reqLen0), .reqLen1(reqLen1),
    .reqAck(reqAck), .rdByte(rdByte), .rdValid(rdValid), .rdLast(rdLast),
    .rdOwner(rdOwner), .busy(busy), .flashClk(flashClk), .flashMosi(flashMosi),
    .flashCs(flashCs), .flashMiso(flashMiso)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // SPI flash model: pins observed mid-cycle; samples MOSI on SCK rise, drives MISO on SCK fall.
  logic [31:0] m_cmd;
  logic [7:0]  m_dummy;
  int          m_bits;
  logic        m_prev_sck = 1'b0;
  always @(negedge clk) begin : flash_model
    int         m_rd;
    logic [7:0] m_b;
    if (flashCs) begin
      m_bits    = 0;
      m_cmd     = 32'd0;
      m_dummy   = 8'd0;
      flashMiso = 1'b0;
    end else begin
      if (flashClk && !m_prev_sck) begin
        if (m_bits < 32)      m_cmd   = {m_cmd[30:0], flashMosi};
        else if (m_bits < 40) m_dummy = {m_dummy[6:0], flashMosi};
        m_bits++;
      end
      if (!flashClk && m_prev_sck && m_bits >= c_hdr_bits) begin
        m_rd      = m_bits - c_hdr_bits;
        m_b       = mem_byte(m_cmd[23:0] + 24'(m_rd / 8));
        flashMiso = m_b[7 - (m_rd % 8)];
      end
    end
    m_prev_sck = flashClk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [23:0] a, input int len);
    q_addr[r] = a;
    q_len[r]  = len;
    if (r == 0) begin reqAddr0 = a; reqLen0 = 8'(len); end
    else        begin reqAddr1 = a; reqLen1 = 8'(len); end
    reqValid[r] = 1'b1;
    pend[r]     = 1'b1;
  endtask

  function automatic int model_grant(input logic [1:0] p, input int last);
    if (p == 2'b11) return (last == 1) ? 0 : 1;
    return p[1] ? 1 : 0;
  endfunction

  task automatic reset_vals(input string tag);
    chk({tag, "_cs"}, flashCs, 1);
    chk({tag, "_sck"}, flashClk, 0);
    chk({tag, "_mosi"}, flashMosi, 0);
    chk({tag, "_ack"}, reqAck, 0);
    chk({tag, "_rdv_last"}, {rdValid, rdLast}, 0);
    chk({tag, "_rdbyte"}, rdByte, 0);
    chk({tag, "_owner"}, rdOwner, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  // Called with rstn just released; the 17th edge must bring busy low.
  task automatic startup_check();
    logic seen_ack = 1'b0;
    logic seen_rdv = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      tick();
      seen_ack |= |reqAck;
      seen_rdv |= rdValid;
      if (e == 16) chk("busy_before_wait_end", busy, 1);
      if (e == 17) chk("busy_after_wait", busy, 0);
    end
    chk("ack_while_busy", seen_ack, 0);
    chk("rdvalid_while_waiting", seen_rdv, 0);
  endtask

  task automatic wait_ack(output int w);
    w = 0;
    do begin
      tick();
      w++;
    end while (reqAck == 2'b00 && w < 300);
    if (reqAck == 2'b00) chk("ack_timeout", 0, 1);
  endtask

  task automatic run_burst(input int g, input logic [23:0] addr, input int len, input int exp_wait);
    int w;
    int last_t;
    int k;
    int unexp = 0;
    int missed = 0;
    wait_ack(w);
    if (reqAck == 2'b00) return;
    if (exp_wait > 0) chk("ack_latency", w, exp_wait);
    chk("ack_onehot", reqAck, 2'b01 << g);
    chk("cs_low_at_ack", flashCs, 0);
    chk("owner_at_ack", rdOwner, g);
    chk("busy_at_ack", busy, 1);
    reqValid[g] = 1'b0;
    last_t = c_first + 16 * len;
    for (int t = 1; t <= last_t + 2; t++) begin
      tick();
      if (t >= c_first && (t - c_first) % 16 == 0) begin
        k = (t - c_first) / 16;
        if (!rdValid) missed++;
        else begin
          chk("rd_byte", rdByte, mem_byte(addr + 24'(k)));
          chk("rd_last", rdLast, (k == len) ? 1 : 0);
          chk("rd_owner", rdOwner, g);
        end
      end else if (rdValid) begin
        unexp++;
      end
      if (t == c_first) begin
        chk("mosi_header", m_cmd, {c_opcode, addr});
        chk("mosi_zero_after_addr", m_dummy, 0);
      end
      if (t == last_t + 1 || t == last_t + 2) chk("cs_high_after_burst", flashCs, 1);
    end
    chk("missed_rdvalid", missed, 0);
    chk("unexpected_rdvalid", unexp, 0);
  endtask

  initial begin
    int g;
    int w;
    int unexp;
    pend   = 2'b00;
    exp_rr = 1;

    // Reset values, start-up wait, and contested first grant.
    set_req(0, 24'h000010, 3);
    set_req(1, 24'($urandom), int'($urandom_range(0, 6)));
    tick();
    tick();
    reset_vals("reset");
    rstn = 1'b1;
    startup_check();
    run_burst(0, 24'h000010, 3, 1);
    pend[0] = 1'b0; exp_rr = 0;
    run_burst(1, q_addr[1], q_len[1], 1);
    pend[1] = 1'b0; exp_rr = 1;

    // Maximum length burst.
    set_req(1, 24'hFFFF00, 255);
    run_burst(1, 24'hFFFF00, 255, -1);
    pend[1] = 1'b0; exp_rr = 1;

    // Single-byte burst from address 0.
    set_req(0, 24'h000000, 0);
    run_burst(0, 24'h000000, 0, -1);
    pend[0] = 1'b0; exp_rr = 0;

    // Randomized request mix against the round-robin rule.
    for (int it = 0; it < 10 || pend != 2'b00; it++) begin
      if (it < 10)
        for (int r = 0; r < 2; r++)
          if (!pend[r] && $urandom_range(0, 2) != 0)
            set_req(r, 24'($urandom), int'($urandom_range(0, 12)));
      if (pend == 2'b00) set_req(0, 24'($urandom), int'($urandom_range(0, 12)));
      g = model_grant(pend, exp_rr);
      run_burst(g, q_addr[g], q_len[g], -1);
      pend[g] = 1'b0;
      exp_rr  = g;
    end

    // Reset in the middle of a burst.
    set_req(0, 24'($urandom), 10);
    set_req(1, 24'($urandom), 4);
    g = model_grant(pend, exp_rr);
    wait_ack(w);
    chk("cut_ack", reqAck, 2'b01 << g);
    reqValid[g] = 1'b0;
    unexp = 0;
    for (int t = 1; t <= 70; t++) begin
      tick();
      if (rdValid) unexp++;
    end
    rstn = 1'b0;
    tick();
    reset_vals("midburst_reset");
    chk("cut_early_rdvalid", unexp, 0);
    tick();
    rstn = 1'b1;
    exp_rr = 1;
    reqValid[g] = 1'b1;
    startup_check();
    run_burst(0, q_addr[0], q_len[0], 1);
    pend[0] = 1'b0; exp_rr = 0;
    run_burst(1, q_addr[1], q_len[1], 1);
    pend[1] = 1'b0; exp_rr = 1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
